// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the serial link (receive and transmit sides).
// Holds the receiver state encoding and the even-parity helper both sides use.
package serial_pkg;

    // PARITY is only reached when the receiver is built with SERIAL_PARITY_EN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } serial_rx_state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int SERIAL_PARITY_MAX_W = 64;

    // XOR reduction of a data word (even-parity bit for that word).
    function automatic logic serial_parity(input logic [SERIAL_PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: MSB-first deserializer with frame-start alignment and a
// one-deep valid/ready holding register on the output.
// Optional feature: define SERIAL_PARITY_EN to expect an even-parity bit after
// each word and report the result on parity_error (constant 0 otherwise).
module serial_to_parallel
    import serial_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            serial,
    input  logic            serial_valid,
    input  logic            frame_start,
    output logic [SIZE-1:0] parallel,
    output logic            parallel_valid,
    input  logic            parallel_ready,
    output logic            overrun,
    output logic            parity_error
);

    localparam int            CW       = $clog2(SIZE + 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

    serial_rx_state_t state_q, state_d;
    logic [SIZE-1:0]  shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SIZE-1:0]  parallel_q;
    logic             valid_q;
    logic             overrun_q;
    logic             perr_q;

    logic             complete;
    logic [SIZE-1:0]  word_d;
    logic             perr_d;

    // Next-state logic: bit assembly, counting, framing and word completion.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        complete = 1'b0;
        word_d   = shift_q;
        perr_d   = 1'b0;

        if (serial_valid && frame_start) begin
            state_d = DATA;
            shift_d = {{(SIZE-1){1'b0}}, serial};
            count_d = ONE;
        end else if (serial_valid) begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                end
                DATA: begin
                    shift_d = {shift_q[SIZE-2:0], serial};
                    if (count_q == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
                        state_d = PARITY;
                        count_d = count_q + ONE;
`else
                        state_d  = IDLE;
                        count_d  = '0;
                        complete = 1'b1;
                        word_d   = {shift_q[SIZE-2:0], serial};
`endif
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
`ifdef SERIAL_PARITY_EN
                PARITY: begin
                    state_d  = IDLE;
                    count_d  = '0;
                    complete = 1'b1;
                    word_d   = shift_q;
                    perr_d   = serial_parity(SERIAL_PARITY_MAX_W'(shift_q)) ^ serial;
                end
`endif
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Receive state, shift register and bit counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Holding register: a completed word always wins over an accept on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parallel_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else if (complete) begin
            parallel_q <= word_d;
            valid_q    <= 1'b1;
            overrun_q  <= valid_q && !parallel_ready;
            perr_q     <= perr_d;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && parallel_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign parallel       = parallel_q;
    assign parallel_valid = valid_q;
    assign overrun        = overrun_q;
    assign parity_error   = perr_q;

endmodule
